// File: rtl/hall_pulse_conditioner_if.sv
// Diagnostic read port of the Hall pulse conditioner: the requester drives a
// channel/select, and the conditioner returns registered data one cycle later.
interface hall_pulse_conditioner_if #(
  parameter int PERIOD_BITS = 16
);
  logic                   rd_en;
  logic [3:0]             rd_chan;
  logic                   rd_sel;
  logic                   rd_valid;
  logic [PERIOD_BITS-1:0] rd_data;

  modport master (
    output rd_en, rd_chan, rd_sel,
    input  rd_valid, rd_data
  );

  modport slave (
    input  rd_en, rd_chan, rd_sel,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/hall_pulse_conditioner.sv
// Per-channel Hall input synchroniser, debounce filter, rising-edge period
// meter and glitch counter, with a registered diagnostic read port.
module hall_pulse_conditioner #(
  parameter int N_CHANNELS  = 6,
  parameter int FILTER_BITS = 8,
  parameter int PERIOD_BITS = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CHANNELS-1:0]   hall_in,
  input  logic [FILTER_BITS-1:0]  filter_len,
  output logic [N_CHANNELS-1:0]   pulse_out,
  output logic [N_CHANNELS-1:0]   rise_strobe,
  output logic [N_CHANNELS-1:0]   stall,
  hall_pulse_conditioner_if.slave rd
);

  localparam logic [PERIOD_BITS-1:0] PERIOD_MAX = '1;
  localparam logic [7:0]             GLITCH_MAX = 8'hFF;

  // Sized to the full rd_chan range; unused entries read as zero.
  logic [PERIOD_BITS-1:0] latched_arr [16];
  logic [7:0]             glitch_arr  [16];

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : ch_g
      if (gi < N_CHANNELS) begin : live_g
        logic                   sync1_q, sync2_q;
        logic [FILTER_BITS-1:0] cnt_q, cnt_d;
        logic                   pulse_q, pulse_d;
        logic                   rise_q, rise_d;
        logic [PERIOD_BITS-1:0] run_q, run_d;
        logic [PERIOD_BITS-1:0] lat_q, lat_d;
        logic                   stall_q, stall_d;
        logic [7:0]             glitch_q, glitch_d;
        logic                   glitch_evt;
        logic                   glitch_clr;

        assign glitch_clr = rd.rd_en && rd.rd_sel && (rd.rd_chan == 4'(gi));

        always_comb begin
          cnt_d      = cnt_q;
          pulse_d    = pulse_q;
          rise_d     = 1'b0;
          glitch_evt = 1'b0;
          if (sync2_q == pulse_q) begin
            cnt_d      = '0;
            glitch_evt = (cnt_q != '0);
          end else if (cnt_q >= filter_len) begin
            pulse_d = sync2_q;
            cnt_d   = '0;
            rise_d  = sync2_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end

          run_d = (run_q == PERIOD_MAX) ? run_q : run_q + 1'b1;
          lat_d = lat_q;
          if (rise_d) begin
            // A saturated running count latches max, which reads as "unknown".
            lat_d = (run_q == PERIOD_MAX) ? PERIOD_MAX : run_q + 1'b1;
            run_d = '0;
          end
          stall_d = (run_d == PERIOD_MAX);

          glitch_d = glitch_q;
          if (glitch_clr) begin
            glitch_d = glitch_evt ? 8'd1 : 8'd0;
          end else if (glitch_evt && glitch_q != GLITCH_MAX) begin
            glitch_d = glitch_q + 1'b1;
          end
        end

        always_ff @(posedge clk) begin
          if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
            rise_q   <= 1'b0;
            run_q    <= PERIOD_MAX;
            lat_q    <= PERIOD_MAX;
            stall_q  <= 1'b1;
            glitch_q <= '0;
          end else begin
            sync1_q  <= hall_in[gi];
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
            rise_q   <= rise_d;
            run_q    <= run_d;
            lat_q    <= lat_d;
            stall_q  <= stall_d;
            glitch_q <= glitch_d;
          end
        end

        assign pulse_out[gi]   = pulse_q;
        assign rise_strobe[gi] = rise_q;
        assign stall[gi]       = stall_q;
        assign latched_arr[gi] = lat_q;
        assign glitch_arr[gi]  = glitch_q;
      end else begin : idle_g
        assign latched_arr[gi] = '0;
        assign glitch_arr[gi]  = '0;
      end
    end
  endgenerate

  logic                   rd_valid_q;
  logic [PERIOD_BITS-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = rd.rd_sel ? PERIOD_BITS'(glitch_arr[rd.rd_chan])
                          : latched_arr[rd.rd_chan];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd.rd_en;
      if (rd.rd_en) begin
        rd_data_q <= rd_data_d;
      end
    end
  end

  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_data  = rd_data_q;

endmodule

// File: tb/tb_hall_pulse_conditioner.sv
// Directed bench for hall_pulse_conditioner: cycle checks on the pulse
// outputs, and a read-port scoreboard drained by an independent monitor.
module tb_hall_pulse_conditioner;

  localparam int N  = 6;
  localparam int FB = 8;
  localparam int PB = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  hall_in;
  logic [FB-1:0] filter_len;
  logic [N-1:0]  pulse_out, rise_strobe, stall;

  hall_pulse_conditioner_if #(.PERIOD_BITS(PB)) rd_bus ();

  hall_pulse_conditioner #(
    .N_CHANNELS(N), .FILTER_BITS(FB), .PERIOD_BITS(PB)
  ) dut (
    .clk(clk), .reset(reset), .hall_in(hall_in), .filter_len(filter_len),
    .pulse_out(pulse_out), .rise_strobe(rise_strobe), .stall(stall),
    .rd(rd_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [PB-1:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle read request; the expected response goes to the scoreboard.
  task automatic rd_req(input logic [3:0] chan, input logic sel, input logic [PB-1:0] exp);
    rd_bus.rd_en   = 1'b1;
    rd_bus.rd_chan = chan;
    rd_bus.rd_sel  = sel;
    exp_q.push_back(exp);
    tick();
    rd_bus.rd_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rd_bus.rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got valid data %0h expected no response", rd_bus.rd_data);
      end else begin
        logic [PB-1:0] e;
        e = exp_q.pop_front();
        if (rd_bus.rd_data !== e) begin
          errors++;
          $display("FAIL rd_data got %0h expected %0h", rd_bus.rd_data, e);
        end else begin
          $display("ok   rd_data = %0h", rd_bus.rd_data);
        end
      end
    end
  end

  initial begin
    reset          = 1'b1;
    hall_in        = '0;
    filter_len     = 8'd4;
    rd_bus.rd_en   = 1'b0;
    rd_bus.rd_chan = '0;
    rd_bus.rd_sel  = 1'b0;

    // Reset values
    tick(3);
    reset = 1'b0;
    chk("reset_pulse_out", 32'(pulse_out), 32'h0);
    chk("reset_rise", 32'(rise_strobe), 32'h0);
    chk("reset_stall", 32'(stall), 32'h3F);
    chk("reset_rd_valid", 32'(rd_bus.rd_valid), 32'h0);
    rd_req(4'd0, 1'b0, 16'hFFFF);
    tick(2);

    // Debounce latency, filter_len = 4: pulse after 7 edges
    hall_in[2] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("deb_pulse_k%0d", k), 32'(pulse_out), (k >= 7) ? 32'h04 : 32'h0);
      chk($sformatf("deb_rise_k%0d", k), 32'(rise_strobe), (k == 7) ? 32'h04 : 32'h0);
    end
    chk("deb_stall_other", 32'(stall & 6'b111011), 32'h3B);

    // Glitch rejection: five 3-cycle pulses on channel 1
    for (int p = 0; p < 5; p++) begin
      hall_in[1] = 1'b1;
      tick(3);
      hall_in[1] = 1'b0;
      tick(8);
      chk($sformatf("glitch_pulse1_p%0d", p), 32'(pulse_out[1]), 32'h0);
    end
    rd_req(4'd1, 1'b1, 16'd5);
    rd_req(4'd1, 1'b1, 16'd0);
    tick(2);

    // Period on channel 0, filter_len = 0, rising edges every 100 cycles
    filter_len = 8'd0;
    chk("period_stall0_before", 32'(stall[0]), 32'h1);
    for (int e = 0; e < 3; e++) begin
      hall_in[0] = 1'b1;
      tick(50);
      chk($sformatf("period_stall0_e%0d", e), 32'(stall[0]), 32'h0);
      hall_in[0] = 1'b0;
      tick(20);
      rd_req(4'd0, 1'b0, (e == 0) ? 16'hFFFF : 16'd100);
      tick(29);
    end

    // Saturation on channel 3
    hall_in[3] = 1'b1;
    tick(3);
    chk("sat_rise3", 32'(rise_strobe[3]), 32'h1);
    chk("sat_stall3_edge", 32'(stall[3]), 32'h0);
    tick(65534);
    chk("sat_stall3_65534", 32'(stall[3]), 32'h0);
    tick(1);
    chk("sat_stall3_65535", 32'(stall[3]), 32'h1);
    tick(4000);
    chk("sat_stall3_held", 32'(stall[3]), 32'h1);
    hall_in[3] = 1'b0;
    tick(5);
    hall_in[3] = 1'b1;
    tick(3);
    chk("sat_rise3_again", 32'(rise_strobe[3]), 32'h1);
    chk("sat_stall3_cleared", 32'(stall[3]), 32'h0);
    rd_req(4'd3, 1'b0, 16'hFFFF);
    tick(2);

    // Glitch event coinciding with a clear-on-read of count 7 (channel 4)
    filter_len = 8'd4;
    for (int p = 0; p < 7; p++) begin
      hall_in[4] = 1'b1;
      tick(2);
      hall_in[4] = 1'b0;
      tick(6);
    end
    hall_in[4] = 1'b1;
    tick(2);
    hall_in[4] = 1'b0;
    tick(2);
    rd_req(4'd4, 1'b1, 16'd7);
    rd_req(4'd4, 1'b1, 16'd1);
    rd_req(4'd4, 1'b1, 16'd0);
    chk("corner_pulse4", 32'(pulse_out[4]), 32'h0);

    // Out-of-range channels
    rd_req(4'd15, 1'b0, 16'd0);
    rd_req(4'd15, 1'b1, 16'd0);
    rd_req(4'd6, 1'b0, 16'd0);
    tick(2);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    // Reset coinciding with a read request aborts it
    rd_bus.rd_en   = 1'b1;
    rd_bus.rd_chan = 4'd0;
    rd_bus.rd_sel  = 1'b0;
    reset          = 1'b1;
    tick();
    rd_bus.rd_en = 1'b0;
    chk("abort_rd_valid", 32'(rd_bus.rd_valid), 32'h0);
    tick();
    chk("abort_rd_valid_next", 32'(rd_bus.rd_valid), 32'h0);
    chk("abort_rd_data", 32'(rd_bus.rd_data), 32'h0);
    hall_in = '0;
    reset   = 1'b0;
    tick();
    chk("abort_stall", 32'(stall), 32'h3F);
    chk("abort_pulse_out", 32'(pulse_out), 32'h0);
    tick(3);
    chk("final_scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
